// File: rtl/affine_addr_decoder_pkg.sv
// Shared types for the affine address decoder: default word width, address word
// and the generator configuration bundle.
package affine_addr_decoder_pkg;

  localparam int unsigned ADDR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t offset;
    addr_t x_max;
    addr_t x_stride;
    addr_t y_stride;
  } affine_cfg_t;

endpackage : affine_addr_decoder_pkg

// File: rtl/affine_coord_tracker.sv
// Walks the (x, y) raster in lock-step with the generator and keeps running
// stride accumulators so the expected address needs only two adds per beat.
module affine_coord_tracker
  import affine_addr_decoder_pkg::*;
#(
  parameter int unsigned W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] offset,
  input  logic [W-1:0] x_max,
  input  logic [W-1:0] x_stride,
  input  logic [W-1:0] y_stride,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic [W-1:0] expected
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] x_reg, x_next;
  logic [W-1:0] y_reg, y_next;
  logic [W-1:0] xacc_reg, xacc_next;
  logic [W-1:0] yacc_reg, yacc_next;
  logic [W-1:0] x_last;
  logic         row_end;

  // x_max=0 makes x_last all-ones, so a row spans the full 2^W range.
  assign x_last  = x_max - ONE;
  assign row_end = (x_reg == x_last);

  always_comb begin
    x_next    = x_reg;
    y_next    = y_reg;
    xacc_next = xacc_reg;
    yacc_next = yacc_reg;
    if (clear) begin
      x_next    = '0;
      y_next    = '0;
      xacc_next = '0;
      yacc_next = '0;
    end else if (advance) begin
      if (row_end) begin
        x_next    = '0;
        xacc_next = '0;
        y_next    = y_reg + ONE;
        yacc_next = yacc_reg + y_stride;
      end else begin
        x_next    = x_reg + ONE;
        xacc_next = xacc_reg + x_stride;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg    <= '0;
      y_reg    <= '0;
      xacc_reg <= '0;
      yacc_reg <= '0;
    end else begin
      x_reg    <= x_next;
      y_reg    <= y_next;
      xacc_reg <= xacc_next;
      yacc_reg <= yacc_next;
    end
  end

  assign x        = x_reg;
  assign y        = y_reg;
  assign expected = offset + xacc_reg + yacc_reg;

endmodule : affine_coord_tracker

// File: rtl/affine_addr_decoder.sv
// Decodes an affine address stream back into (x, y), flagging beats that leave
// the pattern; one-deep output register with valid/ready backpressure.
module affine_addr_decoder
  import affine_addr_decoder_pkg::*;
#(
  parameter int unsigned W = ADDR_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] offset,
  input  logic [W-1:0] x_max,
  input  logic [W-1:0] x_stride,
  input  logic [W-1:0] y_stride,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_addr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_x,
  output logic [W-1:0] out_y,
  output logic         out_match,
  output logic [W-1:0] mismatch_count,
  output logic         err
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic         accept;
  logic         match;
  logic [W-1:0] trk_x;
  logic [W-1:0] trk_y;
  logic [W-1:0] expected;

  logic         out_valid_reg;
  logic [W-1:0] out_x_reg;
  logic [W-1:0] out_y_reg;
  logic         out_match_reg;
  logic [W-1:0] mismatch_count_reg;
  logic         err_reg;

  // Refusing beats during clear keeps a restart from silently eating one.
  assign in_ready = !clear && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign match    = (in_addr == expected);

  affine_coord_tracker #(.W(W)) u_tracker (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .advance  (accept),
    .offset   (offset),
    .x_max    (x_max),
    .x_stride (x_stride),
    .y_stride (y_stride),
    .x        (trk_x),
    .y        (trk_y),
    .expected (expected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg      <= 1'b0;
      out_x_reg          <= '0;
      out_y_reg          <= '0;
      out_match_reg      <= 1'b0;
      mismatch_count_reg <= '0;
      err_reg            <= 1'b0;
    end else if (clear) begin
      out_valid_reg      <= 1'b0;
      mismatch_count_reg <= '0;
      err_reg            <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_x_reg     <= trk_x;
      out_y_reg     <= trk_y;
      out_match_reg <= match;
      if (!match) begin
        err_reg <= 1'b1;
        if (mismatch_count_reg != '1) begin
          mismatch_count_reg <= mismatch_count_reg + ONE;
        end
      end
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid      = out_valid_reg;
  assign out_x          = out_x_reg;
  assign out_y          = out_y_reg;
  assign out_match      = out_match_reg;
  assign mismatch_count = mismatch_count_reg;
  assign err            = err_reg;

endmodule : affine_addr_decoder

// File: tb/tb_affine_addr_decoder.sv
// Scoreboard bench for affine_addr_decoder: the driver queues hand-derived
// expected coordinates, an independent monitor checks every delivered result.
module tb_affine_addr_decoder;
  import affine_addr_decoder_pkg::*;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        m;
    bit          lat;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] offset = '0, x_max = '0, x_stride = '0, y_stride = '0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_x, out_y;
  logic        out_match;
  logic [15:0] mismatch_count;
  logic        err;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   stalls   = 0;
  affine_cfg_t cfg;

  affine_addr_decoder #(.W(16)) dut (
    .clk(clk), .rst_n(rst_n), .offset(offset), .x_max(x_max),
    .x_stride(x_stride), .y_stride(y_stride), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_y(out_y), .out_match(out_match), .mismatch_count(mismatch_count),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result is delivered when out_valid && out_ready at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_x", 32'(out_x), 32'(e.x));
        chk("out_y", 32'(out_y), 32'(e.y));
        chk("out_match", 32'(out_match), 32'(e.m));
        if (e.lat) chk("latency", 32'(cyc), 32'(e.cyc + 1));
        $display("beat x=%0d y=%0d match=%0b (exp %0d,%0d,%0b)",
                 out_x, out_y, out_match, e.x, e.y, e.m);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] ex, input logic [15:0] ey,
                      input logic em, input bit lat);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_addr  = a;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{x: ex, y: ey, m: em, lat: lat, cyc: cyc});
        got = 1'b1;
      end else begin
        stalls++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (sb.size() == 0) done = 1'b1;
    end
    @(posedge clk); #1;
    if (!done) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic set_cfg(input affine_cfg_t c);
    offset = c.offset; x_max = c.x_max; x_stride = c.x_stride; y_stride = c.y_stride;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(mismatch_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out_xy", {out_x, out_y}, 32'd0);
    cfg = '{offset: 16'h0100, x_max: 16'd4, x_stride: 16'd1, y_stride: 16'd4};
    set_cfg(cfg);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic decode at full throughput
    stalls = 0;
    for (int i = 0; i < 12; i++)
      send(16'h0100 + 16'(i), 16'(i % 4), 16'(i / 4), 1'b1, 1'b1);
    chk("basic_stalls", 32'(stalls), 32'd0);
    wait_drain();
    chk("basic_err", 32'(err), 32'd0);
    chk("basic_count", 32'(mismatch_count), 32'd0);
    do_clear();

    // Mismatch injection on the fifth beat
    send(16'h0100, 16'd0, 16'd0, 1'b1, 1'b1);
    send(16'h0101, 16'd1, 16'd0, 1'b1, 1'b1);
    send(16'h0102, 16'd2, 16'd0, 1'b1, 1'b1);
    send(16'h0103, 16'd3, 16'd0, 1'b1, 1'b1);
    send(16'h0200, 16'd0, 16'd1, 1'b0, 1'b1);
    send(16'h0105, 16'd1, 16'd1, 1'b1, 1'b1);
    wait_drain();
    chk("mm_count", 32'(mismatch_count), 32'd1);
    chk("mm_err", 32'(err), 32'd1);

    // Backpressure: hold result A while B waits
    out_ready = 1'b0;
    send(16'h0106, 16'd2, 16'd1, 1'b1, 1'b0);
    fork
      send(16'h0107, 16'd3, 16'd1, 1'b1, 1'b0);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("bp_in_ready", 32'(in_ready), 32'd0);
          chk("bp_out_valid", 32'(out_valid), 32'd1);
          chk("bp_hold", {out_x, out_y}, {16'd2, 16'd1});
          chk("bp_hold_match", 32'(out_match), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("bp_count", 32'(mismatch_count), 32'd1);

    // clear mid-frame with a beat offered in the same cycle
    send(16'h0108, 16'd0, 16'd2, 1'b1, 1'b1);
    clear = 1'b1; in_valid = 1'b1; in_addr = 16'h0109;
    @(negedge clk);
    chk("clr_in_ready", 32'(in_ready), 32'd0);
    chk("clr_err_before", 32'(err), 32'd1);
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    chk("clr_count", 32'(mismatch_count), 32'd0);
    chk("clr_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    send(16'h0100, 16'd0, 16'd0, 1'b1, 1'b1);
    wait_drain();
    chk("clr_restart_err", 32'(err), 32'd0);

    // Address wrap with a one-wide row
    do_clear();
    cfg = '{offset: 16'hFFFE, x_max: 16'd1, x_stride: 16'd5, y_stride: 16'd1};
    set_cfg(cfg);
    send(16'hFFFE, 16'd0, 16'd0, 1'b1, 1'b1);
    send(16'hFFFF, 16'd0, 16'd1, 1'b1, 1'b1);
    send(16'h0000, 16'd0, 16'd2, 1'b1, 1'b1);
    wait_drain();
    chk("wrap_err", 32'(err), 32'd0);

    // Async reset while a result is pending
    send(16'h0005, 16'd0, 16'd3, 1'b0, 1'b1);
    send(16'h0002, 16'd0, 16'd4, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    chk("ar_pre_err", 32'(err), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_count", 32'(mismatch_count), 32'd0);
    chk("ar_err", 32'(err), 32'd0);
    chk("ar_out_xy", {out_x, out_y}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'hFFFE, 16'd0, 16'd0, 1'b1, 1'b1);
    send(16'hFFFF, 16'd0, 16'd1, 1'b1, 1'b1);
    wait_drain();
    chk("ar_restart_err", 32'(err), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_affine_addr_decoder
